fifo_rd_streamer: RTL and testbench
===================================

FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 Parameter CNT_WIDTH, default 16, width of pop_count.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port rclk  input  1  read-domain clock; all state on rising edge.
REQ-005 Port rrst_n  input  1  asynchronous active-low reset.
REQ-006 Port enable  input  1  run request; 1 = pop FIFO, 0 = stop popping and drain.
REQ-007 Port fifo_empty  input  1  FIFO empty flag, read-clock domain.
REQ-008 Port fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after a fifo_r_en pulse.
REQ-009 Port fifo_r_en  output  1  FIFO pop request.
REQ-010 Port m_data  output  DATA_WIDTH  stream data.
REQ-011 Port m_valid  output  1  stream data valid.
REQ-012 Port m_ready  input  1  downstream accept.
REQ-013 Port busy  output  1  high whenever state != IDLE.
REQ-014 Port pop_count  output  CNT_WIDTH  total pops issued, wrapping.

Function
REQ-015 State machine SHALL have states IDLE, ACTIVE, DRAIN: IDLE->ACTIVE on enable=1; ACTIVE->DRAIN on enable=0; DRAIN->ACTIVE on enable=1; DRAIN->IDLE when enable=0, inflight=0 and occ=0.
REQ-016 The block SHALL hold a 3-entry output buffer (occ 0..3) and a 1-bit inflight register.
REQ-017 fifo_r_en SHALL be combinational: state==ACTIVE && !fifo_empty && (occ + inflight) < 3; it SHALL NOT depend on m_ready.
REQ-018 inflight SHALL register fifo_r_en; when inflight=1, fifo_data SHALL be written into the buffer tail that cycle.
REQ-019 m_valid SHALL equal (occ != 0), and m_data SHALL be the buffer head.
REQ-020 A transfer SHALL occur when m_valid && m_ready; it removes the head.
REQ-021 Simultaneous write and transfer SHALL leave occ unchanged and preserve order.
REQ-022 m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 occ + inflight SHALL never exceed 3; the buffer SHALL never overflow or drop data.
REQ-024 With m_ready held 1 and the FIFO non-empty, the block SHALL sustain one word per cycle; first-word latency is 2 cycles from fifo_r_en to m_valid.
REQ-025 pop_count SHALL increment by 1 on every cycle with fifo_r_en=1 and wrap from 2^CNT_WIDTH-1 to 0.
REQ-026 In DRAIN, words already buffered or inflight SHALL still be delivered in order; no new pops are issued.

Reset
REQ-027 On rrst_n=0, asynchronously: state=IDLE, occ=0, inflight=0, pop_count=0, buffer contents and m_data=0, m_valid=0, busy=0, fifo_r_en=0.
REQ-028 Reset mid-operation SHALL discard buffered and inflight data; after release, the block resumes in IDLE.

Structure
REQ-029 Package fifo_rd_pkg SHALL hold the state enum (IDLE, ACTIVE, DRAIN) and constant SKID_DEPTH=3.
REQ-030 The 3-entry buffer SHALL be one sub-module, rd_skid_buf, parameterised by DATA_WIDTH and SKID_DEPTH, with ports wr, wdata, rd, rdata, occ.

Verification
REQ-031 Stream: enable=1, FIFO preloaded with 0x11..0x18, m_ready=1 -> m_data 0x11..0x18 on 8 consecutive cycles; pop_count=8; after enable=0, busy falls within 3 cycles.
REQ-032 Backpressure: m_ready=0 with 5 words available -> exactly 3 pops, occ=3, m_data held at the first word; m_ready=1 -> all 5 words delivered in order.
REQ-033 Empty guard: fifo_empty=1 and enable=1 for 10 cycles -> fifo_r_en=0, m_valid=0, busy=1.
REQ-034 Drain: enable dropped with occ=2 and inflight=1 -> 3 words delivered, no new fifo_r_en, state reaches IDLE.
REQ-035 Reset mid-stream: rrst_n=0 with occ=2 -> m_valid=0 and pop_count=0 immediately (asynchronously), with no stale word after release.
REQ-036 Wrap: pop_count preset by 0xFFFF pops, then one more pop -> pop_count=0x0000.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared state encoding and skid-buffer sizing for the FIFO read streamer
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 3;
  localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - small in-order output buffer, head always held in entry 0
module rd_skid_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int SKID_DEPTH = 3,
  localparam int OCC_W     = $clog2(SKID_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [OCC_W-1:0]      occ
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [OCC_W-1:0]      wr_idx;
  logic                  rd_eff, wr_eff;

  assign rd_eff = rd && (occ_q != '0);
  assign wr_eff = wr && ((int'(occ_q) < SKID_DEPTH) || rd_eff);
  // A simultaneous pop shifts everything down, so the new tail lands one slot lower.
  assign wr_idx = rd_eff ? (occ_q - {{(OCC_W-1){1'b0}}, 1'b1}) : occ_q;

  always_comb begin
    mem_d = mem_q;
    if (rd_eff) begin
      for (int i = 0; i < SKID_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[SKID_DEPTH-1] = '0;
    end
    if (wr_eff) begin
      mem_d[wr_idx] = wdata;
    end
    occ_d = occ_q + {{(OCC_W-1){1'b0}}, wr_eff} - {{(OCC_W-1){1'b0}}, rd_eff};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      occ_q <= occ_d;
    end
  end

  assign rdata = mem_q[0];
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_rd_streamer.sv
// rtl/fifo_rd_streamer.sv - pops a read-domain FIFO into a valid/ready stream without overrunning the skid buffer
module fifo_rd_streamer
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  rd_state_e            state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
  logic [OCC_WIDTH-1:0] occ;
  logic [OCC_WIDTH:0]   fill;
  logic                 xfer;

  // Count the word still in flight from the FIFO so a full buffer is never overrun.
  assign fill      = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight_q};
  assign fifo_r_en = (state_q == ACTIVE) && !fifo_empty && (int'(fill) < SKID_DEPTH);
  assign m_valid   = (occ != '0);
  assign xfer      = m_valid && m_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ACTIVE;
      ACTIVE:  if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) state_d = ACTIVE;
        else if (!inflight_q && (occ == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    inflight_d  = fifo_r_en;
    busy_d      = (state_d != IDLE);
    pop_count_d = pop_count_q + {{(CNT_WIDTH-1){1'b0}}, fifo_r_en};
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= IDLE;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      pop_count_q <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      pop_count_q <= pop_count_d;
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (rclk),
    .rst_n (rrst_n),
    .wr    (inflight_q),
    .wdata (fifo_data),
    .rd    (xfer),
    .rdata (m_data),
    .occ   (occ)
  );

  assign busy      = busy_q;
  assign pop_count = pop_count_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb/tb_fifo_rd_streamer.sv - directed self-checking bench for fifo_rd_streamer
module tb_fifo_rd_streamer;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_r_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic [15:0] pop_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic       fifo_inf = 1'b0;

  fifo_rd_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .pop_count  (pop_count)
  );

  always #5 rclk = ~rclk;

  assign fifo_empty = !fifo_inf && (rd_ptr == wr_ptr);

  always @(posedge rclk) begin
    if (fifo_r_en) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr++;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (m_valid !== 1'b1 && n < max_cyc) begin
      @(negedge rclk);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
  endtask

  initial begin
    logic [15:0] pc0;
    logic [15:0] dlt;
    int          n;

    rrst_n  = 1'b0;
    enable  = 1'b0;
    m_ready = 1'b0;
    fifo_data = 8'h00;
    repeat (2) @(negedge rclk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_r_en", {31'd0, fifo_r_en}, 32'd0);
    chk("rst_pop_count", {16'd0, pop_count}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    rrst_n = 1'b1;
    @(negedge rclk);

    // Streaming: eight words back to back at full rate.
    for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
    m_ready = 1'b1;
    enable  = 1'b1;
    wait_valid("stream_first", 10);
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", {31'd0, m_valid}, 32'd1);
      chk("stream_data", {24'd0, m_data}, 32'h11 + i);
      @(negedge rclk);
    end
    chk("stream_done_valid", {31'd0, m_valid}, 32'd0);
    chk("stream_pop_count", {16'd0, pop_count}, 32'd8);
    enable = 1'b0;
    repeat (3) @(negedge rclk);
    chk("stream_busy_fall", {31'd0, busy}, 32'd0);

    // Backpressure: only three pops while stalled.
    pc0 = pop_count;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
    enable = 1'b1;
    repeat (10) @(negedge rclk);
    dlt = pop_count - pc0;
    chk("bp_pops", {16'd0, dlt}, 32'd3);
    chk("bp_occ", {30'd0, dut.u_skid.occ}, 32'd3);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_hold_data", {24'd0, m_data}, 32'h21);
    chk("bp_r_en", {31'd0, fifo_r_en}, 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("bp_word", 5);
      chk("bp_data", {24'd0, m_data}, 32'h21 + i);
      @(negedge rclk);
    end
    dlt = pop_count - pc0;
    chk("bp_total_pops", {16'd0, dlt}, 32'd5);

    // Empty guard: enabled but FIFO empty.
    for (int i = 0; i < 10; i++) begin
      chk("empty_r_en", {31'd0, fifo_r_en}, 32'd0);
      chk("empty_valid", {31'd0, m_valid}, 32'd0);
      chk("empty_busy", {31'd0, busy}, 32'd1);
      @(negedge rclk);
    end

    // Drain with two buffered and one in flight; one word left in FIFO must stay.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
    repeat (3) @(negedge rclk);
    chk("drain_occ", {30'd0, dut.u_skid.occ}, 32'd2);
    chk("drain_inflight", {31'd0, dut.inflight_q}, 32'd1);
    pc0 = pop_count;
    enable  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_valid", {31'd0, m_valid}, 32'd1);
      chk("drain_data", {24'd0, m_data}, 32'h31 + i);
      chk("drain_no_pop", {31'd0, fifo_r_en}, 32'd0);
      @(negedge rclk);
    end
    n = 0;
    while (busy !== 1'b0 && n < 5) begin
      @(negedge rclk);
      n++;
    end
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("drain_pop_count", {16'd0, pop_count}, {16'd0, pc0});
    chk("drain_after_valid", {31'd0, m_valid}, 32'd0);

    // Reset mid-stream with two buffered words (0x34 left over plus 0x41).
    m_ready = 1'b0;
    push(8'h41);
    enable = 1'b1;
    repeat (6) @(negedge rclk);
    chk("mrst_occ", {30'd0, dut.u_skid.occ}, 32'd2);
    chk("mrst_head", {24'd0, m_data}, 32'h34);
    rrst_n = 1'b0;
    #1;
    chk("mrst_async_valid", {31'd0, m_valid}, 32'd0);
    chk("mrst_async_pop_count", {16'd0, pop_count}, 32'd0);
    chk("mrst_async_busy", {31'd0, busy}, 32'd0);
    chk("mrst_async_data", {24'd0, m_data}, 32'd0);
    @(negedge rclk);
    rrst_n = 1'b1;
    repeat (3) begin
      @(negedge rclk);
      chk("mrst_no_stale", {31'd0, m_valid}, 32'd0);
    end
    m_ready = 1'b1;
    push(8'h51);
    wait_valid("mrst_fresh", 6);
    chk("mrst_fresh_data", {24'd0, m_data}, 32'h51);
    @(negedge rclk);
    chk("mrst_fresh_done", {31'd0, m_valid}, 32'd0);

    // Wrap: count 0xFFFF pops from reset, then one more.
    rrst_n = 1'b0;
    @(negedge rclk);
    rrst_n   = 1'b1;
    fifo_inf = 1'b1;
    n = 0;
    while (pop_count !== 16'hFFFF && n < 70000) begin
      @(negedge rclk);
      n++;
    end
    fifo_inf = 1'b0;
    wr_ptr   = rd_ptr;
    chk("wrap_preset", {16'd0, pop_count}, 32'hFFFF);
    @(negedge rclk);
    chk("wrap_hold", {16'd0, pop_count}, 32'hFFFF);
    push(8'h66);
    @(negedge rclk);
    chk("wrap_zero", {16'd0, pop_count}, 32'h0000);
    enable = 1'b0;
    repeat (6) @(negedge rclk);
    chk("wrap_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
